// File: rtl/switch_pio_debounced_if.sv
// Avalon-MM slave bus bundle for the debounced switch PIO.
interface switch_pio_debounced_if;
  logic [1:0]  address;
  logic        write;
  logic        chipselect;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, write, chipselect, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, write, chipselect, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/switch_pio_debounced.sv
// Switch/button PIO: synchroniser, per-bit debouncer, W1C edge capture and
// maskable level interrupt behind a 4-word Avalon-MM register map.
module switch_pio_debounced #(
  parameter int               WIDTH           = 18,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] IRQ_MASK_RESET  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  switch_pio_debounced_if.slave bus
);

  logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr_bits;
  logic [31:0]      rd_mux;
  logic [31:0]      readdata_r;
  logic             irq_r;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^bus.writedata;
  assign wr_en        = bus.chipselect & bus.write;
  assign wdata        = bus.writedata[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_ff[s] <= '0;
    end else begin
      sync_ff[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_ff[s] <= sync_ff[s-1];
    end
  end

  assign sync = sync_ff[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk) begin
        if (reset) deb <= '0;
        else       deb <= sync;
      end
    end else begin : g_debounce
      localparam int             CW     = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0]  CNT_TC = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] cnt [WIDTH];

      // A bit is accepted on the last of DEBOUNCE_CYCLES consecutive differing
      // cycles; any agreeing cycle restarts the count, so the counter never wraps.
      always_ff @(posedge clk) begin
        if (reset) begin
          deb <= '0;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == deb[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_TC) begin
              deb[i] <= sync[i];
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
        end
      end
    end
  endgenerate

  always_comb begin
    edge_det = deb ^ deb_d;
    if (EDGE_TYPE == 0)      edge_det = deb & ~deb_d;
    else if (EDGE_TYPE == 1) edge_det = ~deb & deb_d;
  end

  always_comb begin
    clr_bits = '0;
    if (wr_en && bus.address == 2'd3) clr_bits = wdata;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0:    rd_mux[WIDTH-1:0] = deb;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_cap;
      default: rd_mux = '0;
    endcase
  end

  // A new edge overrides a simultaneous write-clear of the same bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_d      <= '0;
      edge_cap   <= '0;
      irq_mask   <= IRQ_MASK_RESET;
      irq_r      <= 1'b0;
      readdata_r <= '0;
    end else begin
      deb_d      <= deb;
      edge_cap   <= (edge_cap & ~clr_bits) | edge_det;
      if (wr_en && bus.address == 2'd2) irq_mask <= wdata;
      irq_r      <= |(edge_cap & irq_mask);
      readdata_r <= rd_mux;
    end
  end

  assign bus.readdata = readdata_r;
  assign bus.irq      = irq_r;

endmodule

// File: tb/tb_switch_pio_debounced.sv
// Bench for switch_pio_debounced: three configurations (rising, any-edge,
// 32-bit bypass) checked through a queue of expected read results.
module tb_switch_pio_debounced;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        write_s;
  logic [31:0] writedata;
  logic [2:0]  cs;
  logic [17:0] in_a;
  logic [17:0] in_b;
  logic [31:0] in_c;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] got;
  logic [31:0] e;

  always #5 clk = ~clk;

  switch_pio_debounced_if if_a ();
  switch_pio_debounced_if if_b ();
  switch_pio_debounced_if if_c ();

  assign if_a.address = address;  assign if_a.write = write_s;
  assign if_a.writedata = writedata; assign if_a.chipselect = cs[0];
  assign if_b.address = address;  assign if_b.write = write_s;
  assign if_b.writedata = writedata; assign if_b.chipselect = cs[1];
  assign if_c.address = address;  assign if_c.write = write_s;
  assign if_c.writedata = writedata; assign if_c.chipselect = cs[2];

  switch_pio_debounced #(.WIDTH(18), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0))
    dut_a (.clk(clk), .reset(reset), .in_port(in_a), .bus(if_a));
  switch_pio_debounced #(.WIDTH(18), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2))
    dut_b (.clk(clk), .reset(reset), .in_port(in_b), .bus(if_b));
  switch_pio_debounced #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0))
    dut_c (.clk(clk), .reset(reset), .in_port(in_c), .bus(if_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic rd(input int sel, input logic [1:0] addr, output logic [31:0] val);
    address = addr;
    tick();
    val = (sel == 0) ? if_a.readdata : (sel == 1) ? if_b.readdata : if_c.readdata;
  endtask

  task automatic wr(input int sel, input logic [1:0] addr, input logic [31:0] data);
    address   = addr;
    writedata = data;
    write_s   = 1'b1;
    cs        = 3'b001 << sel;
    tick();
    write_s   = 1'b0;
    cs        = 3'b000;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_a = 18'h3FFFF; in_b = 18'h3FFFF; in_c = 32'hFFFF_FFFF;
    wait_cyc(3);
    exp_q.push_back(32'h0); rd(0, 2'd0, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL rst_readdata_a: got %h want %h", got, e); end
    exp_q.push_back(32'h0); got = 32'(if_a.irq); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL rst_irq_a: got %h want %h", got, e); end
    exp_q.push_back(32'h0); got = if_c.readdata; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL rst_readdata_c: got %h want %h", got, e); end
    in_a = '0; in_b = '0; in_c = '0;
    wait_cyc(3);
    reset = 1'b0;
    exp_q.push_back(32'h0); rd(0, 2'd2, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL rst_mask: got %h want %h", got, e); end
    address = 2'd2; writedata = 32'h1; write_s = 1'b1; cs = 3'b000;
    tick();
    write_s = 1'b0;
    exp_q.push_back(32'h0); rd(0, 2'd2, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL write_no_cs: got %h want %h", got, e); end
    wr(0, 2'd1, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0); rd(0, 2'd1, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL addr1_read: got %h want %h", got, e); end
    wr(0, 2'd0, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0); rd(0, 2'd0, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL data_readonly: got %h want %h", got, e); end
  endtask

  task automatic test_debounce();
    in_a[0] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      if (i == 6) exp_q.push_back(32'h0);
      if (i == 7) exp_q.push_back(32'h1);
      rd(0, 2'd0, got);
      if (i >= 6) begin
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL deb_latency_%0d: got %h want %h", i, got, e); end
      end
    end
    in_a[1] = 1'b1;
    wait_cyc(3);
    in_a[1] = 1'b0;
    wait_cyc(12);
    exp_q.push_back(32'h1); rd(0, 2'd0, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL glitch_data: got %h want %h", got, e); end
    exp_q.push_back(32'h1); rd(0, 2'd3, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL glitch_cap: got %h want %h", got, e); end
    wr(0, 2'd3, 32'h3FFFF);
    in_a[0] = 1'b0;
    wait_cyc(12);
    exp_q.push_back(32'h0); rd(0, 2'd3, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL rise_ignores_fall: got %h want %h", got, e); end
  endtask

  task automatic test_edge_irq();
    wr(0, 2'd2, 32'hFFFF_FFFF);
    exp_q.push_back(32'h3FFFF); rd(0, 2'd2, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL mask_width: got %h want %h", got, e); end
    wr(0, 2'd2, 32'h1);
    in_a[0] = 1'b1;
    wait_cyc(10);
    exp_q.push_back(32'h1); rd(0, 2'd3, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL cap_bit0: got %h want %h", got, e); end
    exp_q.push_back(32'h1); got = 32'(if_a.irq); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL irq_bit0: got %h want %h", got, e); end
    in_a[5] = 1'b1;
    wait_cyc(10);
    exp_q.push_back(32'h21); rd(0, 2'd3, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL cap_bit5: got %h want %h", got, e); end
    wr(0, 2'd3, 32'h1);
    exp_q.push_back(32'h1); got = 32'(if_a.irq); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL irq_clear_lag: got %h want %h", got, e); end
    exp_q.push_back(32'h20); rd(0, 2'd3, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL cap_after_clear: got %h want %h", got, e); end
    exp_q.push_back(32'h0); got = 32'(if_a.irq); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL irq_after_clear: got %h want %h", got, e); end
    wr(0, 2'd2, 32'h20);
    exp_q.push_back(32'h0); got = 32'(if_a.irq); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL irq_unmask_lag: got %h want %h", got, e); end
    tick();
    exp_q.push_back(32'h1); got = 32'(if_a.irq); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL irq_unmask: got %h want %h", got, e); end
    wr(0, 2'd2, 32'h0);
    tick();
    exp_q.push_back(32'h0); got = 32'(if_a.irq); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL irq_mask_drop: got %h want %h", got, e); end
    wr(0, 2'd3, 32'hFFFF_FFFF);
  endtask

  task automatic test_collision();
    in_a[2] = 1'b1;
    wait_cyc(6);
    wr(0, 2'd3, 32'h4);
    exp_q.push_back(32'h4); rd(0, 2'd3, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL set_beats_clear: got %h want %h", got, e); end
    wr(0, 2'd3, 32'h0);
    exp_q.push_back(32'h4); rd(0, 2'd3, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL clear_zero_noop: got %h want %h", got, e); end
    wr(0, 2'd3, 32'h4);
    exp_q.push_back(32'h0); rd(0, 2'd3, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL clear_bit2: got %h want %h", got, e); end
  endtask

  task automatic test_any_edge();
    in_b[3] = 1'b1;
    wait_cyc(10);
    exp_q.push_back(32'h8); rd(1, 2'd3, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL any_rise: got %h want %h", got, e); end
    wr(1, 2'd3, 32'h8);
    exp_q.push_back(32'h0); rd(1, 2'd3, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL any_clear1: got %h want %h", got, e); end
    in_b[3] = 1'b0;
    wait_cyc(10);
    exp_q.push_back(32'h8); rd(1, 2'd3, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL any_fall: got %h want %h", got, e); end
    in_b[3] = 1'b1;
    wait_cyc(10);
    wr(1, 2'd3, 32'h8);
    exp_q.push_back(32'h0); rd(1, 2'd3, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL any_single_clear: got %h want %h", got, e); end
  endtask

  task automatic test_bypass_reset();
    in_c = 32'hDEAD_BEEF;
    for (int i = 1; i <= 4; i++) begin
      if (i == 3) exp_q.push_back(32'h0);
      if (i == 4) exp_q.push_back(32'hDEAD_BEEF);
      rd(2, 2'd0, got);
      if (i >= 3) begin
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL bypass_latency_%0d: got %h want %h", i, got, e); end
      end
    end
    wait_cyc(3);
    exp_q.push_back(32'hDEAD_BEEF); rd(2, 2'd3, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL cap_32: got %h want %h", got, e); end
    wr(2, 2'd2, 32'hFFFF_FFFF);
    tick();
    exp_q.push_back(32'h1); got = 32'(if_c.irq); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL irq_32: got %h want %h", got, e); end
    in_c = 32'h1234_5678;
    address = 2'd2;
    tick();
    reset = 1'b1;
    tick();
    exp_q.push_back(32'h0); got = if_c.readdata; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL midrst_readdata: got %h want %h", got, e); end
    exp_q.push_back(32'h0); got = 32'(if_c.irq); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL midrst_irq: got %h want %h", got, e); end
    in_c = '0;
    reset = 1'b0;
    exp_q.push_back(32'h0); rd(2, 2'd2, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL midrst_mask: got %h want %h", got, e); end
    exp_q.push_back(32'h0); rd(2, 2'd3, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL midrst_cap: got %h want %h", got, e); end
    exp_q.push_back(32'h0); rd(2, 2'd0, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL midrst_data: got %h want %h", got, e); end
  endtask

  initial begin
    reset = 1'b1; address = '0; write_s = 1'b0; writedata = '0; cs = '0;
    in_a = '0; in_b = '0; in_c = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_debounce();
    test_edge_irq();
    test_collision();
    test_any_edge();
    test_bypass_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
